// File: rtl/deser_pkg.sv
// deser_pkg: shared types, limits and helpers for the multi-lane deserializer.
package deser_pkg;
    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;
    localparam int MAX_LANES = 8;
    function automatic int beats_f(input int width, input int lanes);
        return width / lanes;
    endfunction
endpackage

// File: rtl/deser_out_reg.sv
// deser_out_reg: single-entry output holding register with valid/ready and drop pulse.
import deser_pkg::*;
module deser_out_reg #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
) (
    input  logic             i_clk,
    input  logic             i_arstn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [LEN_W-1:0] o_len,
    output logic             o_val,
    output logic             o_ovf
);
    out_state_t       r_state;
    logic [WIDTH-1:0] r_data;
    logic [LEN_W-1:0] r_len;
    logic             r_ovf;
    // A free slot exists when empty or when the held word leaves this cycle.
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_state <= OUT_EMPTY;
            r_data  <= '0;
            r_len   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            if (r_state == OUT_EMPTY || i_ready) begin
                if (i_load) begin
                    r_data  <= i_data;
                    r_len   <= i_len;
                    r_state <= OUT_FULL;
                end else begin
                    r_state <= OUT_EMPTY;
                end
            end else begin
                r_ovf <= i_load;
            end
        end
    end
    assign o_data = r_data;
    assign o_len  = r_len;
    assign o_val  = (r_state == OUT_FULL);
    assign o_ovf  = r_ovf;
endmodule

// File: rtl/deserializer_mlane.sv
// deserializer_mlane: LANES-bit beats into WIDTH-bit words, MSB- or LSB-first, with early last.
// Optional DESER_MLANE_WORD_CNT_EN adds handshake and drop counters.
import deser_pkg::*;
module deserializer_mlane #(
    parameter int WIDTH     = 16,
    parameter int LANES     = 1,
    parameter int LSB_FIRST = 0
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    input  logic [LANES-1:0]        data_i,
    input  logic                    data_val_i,
    input  logic                    data_last_i,
    output logic [WIDTH-1:0]        deser_data_o,
    output logic [$clog2(WIDTH):0]  deser_len_o,
    output logic                    deser_data_val_o,
    input  logic                    deser_ready_i,
`ifdef DESER_MLANE_WORD_CNT_EN
    output logic [15:0]             word_cnt_o,
    output logic [15:0]             drop_cnt_o,
`endif
    output logic                    ovf_o
);
    localparam int BEATS = WIDTH / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LEN_W = $clog2(WIDTH) + 1;
    if ((beats_f(WIDTH, LANES) * LANES != WIDTH) || (LANES > MAX_LANES)) begin : g_bad_params
        $error("deserializer_mlane: WIDTH must be a multiple of LANES and LANES <= MAX_LANES");
    end
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_word;
    logic [LEN_W-1:0] w_len;
    logic [LEN_W-1:0] w_pad;
    logic             w_done;
    // Shift a beat in, then align a short word to the end the first beat belongs to.
    always_comb begin
        w_done  = data_val_i & ((r_cnt == CNT_W'(BEATS - 1)) | data_last_i);
        w_len   = LEN_W'((int'(r_cnt) + 1) * LANES);
        w_pad   = LEN_W'(WIDTH) - w_len;
        w_shift = (LSB_FIRST != 0) ? ((r_shift >> LANES) | (WIDTH'(data_i) << (WIDTH - LANES)))
                                   : ((r_shift << LANES) | WIDTH'(data_i));
        w_word  = (LSB_FIRST != 0) ? (w_shift >> w_pad) : (w_shift << w_pad);
    end
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (data_val_i) begin
            r_cnt   <= w_done ? '0 : r_cnt + CNT_W'(1);
            r_shift <= w_done ? '0 : w_shift;
        end
    end
    deser_out_reg #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_out (
        .i_clk   (clk_i),
        .i_arstn (arstn_i),
        .i_load  (w_done),
        .i_data  (w_word),
        .i_len   (w_len),
        .i_ready (deser_ready_i),
        .o_data  (deser_data_o),
        .o_len   (deser_len_o),
        .o_val   (deser_data_val_o),
        .o_ovf   (ovf_o)
    );
`ifdef DESER_MLANE_WORD_CNT_EN
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            word_cnt_o <= '0;
            drop_cnt_o <= '0;
        end else begin
            if (deser_data_val_o && deser_ready_i) word_cnt_o <= word_cnt_o + 16'd1;
            if (ovf_o && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end
`endif
endmodule

// File: doc/deserializer_mlane.md
Name: deserializer_mlane

Overview:
- Parametrised successor of the single-bit serial-to-parallel deserializer.
- Collects LANES bits per valid beat into a WIDTH-bit word, in MSB-first or LSB-first order.
- Supports early termination of a short word via a last flag.
- Holds each completed word in an output register with a valid/ready handshake and reports dropped words.
- Sits between a serial link front end and word-wide datapath consumers.

Parameters:
- WIDTH, 16: output word width in bits; must be a multiple of LANES and at least 2.
- LANES, 1: bits delivered per input beat (1, 2, 4 or 8).
- LSB_FIRST, 0: 0 means the first beat lands in the MSBs; 1 means the first beat lands in the LSBs.
- Derived localparam BEATS = WIDTH/LANES.
- Derived localparam CNT_W = $clog2(BEATS).
- Derived localparam LEN_W = $clog2(WIDTH)+1.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- arstn_i  input  1  reset; one clock; reset is asynchronous and active-low.
- data_i  input  LANES  serial beat; within a beat, bit LANES-1 is the earlier bit when LSB_FIRST=0 and bit 0 is the earlier bit when LSB_FIRST=1.
- data_val_i  input  1  beat qualifier.
- data_last_i  input  1  marks the final beat of a word; only meaningful with data_val_i.
- deser_data_o  output  WIDTH  assembled word.
- deser_len_o  output  LEN_W  number of valid bits in deser_data_o (1..WIDTH, multiple of LANES).
- deser_data_val_o  output  1  output word valid.
- deser_ready_i  input  1  consumer accepts the word.
- ovf_o  output  1  one-cycle pulse: a completed word was dropped.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - beat counter and shift register cleared.
  - deser_data_o = 0, deser_len_o = 0, deser_data_val_o = 0, ovf_o = 0.
  - Reset mid-word discards the partial word; no output is produced.
- Accumulation:
  - Each cycle with data_val_i=1 shifts one beat into the shift register and increments the counter.
  - Cycles with data_val_i=0 hold all state; gaps of any length are allowed.
  - data_last_i is ignored when data_val_i=0.
- Completion: a beat completes the word when data_val_i=1 AND (counter==BEATS-1 OR data_last_i=1).
  - On completion the counter returns to 0 on the same edge, so the next beat starts a new word with no dead cycle.
- Short word of n bits (data_last_i before a full word):
  - LSB_FIRST=0: bits are left-aligned in deser_data_o[WIDTH-1 -: n] and the lower bits are 0.
  - LSB_FIRST=1: bits sit in deser_data_o[n-1:0] and the upper bits are 0.
- A full word (including data_last_i on beat BEATS-1) gives deser_len_o = WIDTH.
- Latency: deser_data_val_o rises on the edge after the completing beat, i.e. one cycle.
- Output register, two states EMPTY and FULL:
  - EMPTY + completion: load data/len, go to FULL.
  - FULL + deser_ready_i=1 and no completion: go to EMPTY; data/len hold their last value.
  - FULL + deser_ready_i=1 + completion in the same cycle: load the new word and stay FULL (back-to-back, no bubble).
  - FULL + deser_ready_i=0 + completion: the new word is discarded, the held word is unchanged, ovf_o=1 for exactly one cycle.
- deser_data_o and deser_len_o are stable while deser_data_val_o=1 and deser_ready_i=0.
- Serial input has no backpressure; the accumulator never stalls.

Optional Feature:
- Macro: DESER_MLANE_WORD_CNT_EN.
- Defined:
  - Adds output port word_cnt_o [15:0], reset to 0.
  - Increments on every accepted handshake (deser_data_val_o & deser_ready_i) and wraps 0xFFFF to 0x0000.
  - Adds output port drop_cnt_o [15:0], which increments on each ovf_o and saturates at 0xFFFF.
- Undefined: neither port exists; all other behaviour is identical.

Decomposition:
- Package deser_pkg:
  - typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t.
  - Function beats_f(width, lanes) used by the parameter legality check.
  - Localparam MAX_LANES = 8.
- Sub-module deser_out_reg: holds the EMPTY/FULL state machine, the data/len register and ovf generation. The top-level keeps the shift register and beat counter.
- Elaboration-time $error if WIDTH % LANES != 0 or LANES > MAX_LANES.

Test Plan:
- WIDTH=16, LANES=1, LSB_FIRST=0, ready held 1, MSB-first stream of 0xB7E4, 0x2167, 0xE9D3 with no gaps -> three words out, each exactly 1 cycle after its 16th bit, len=16, ovf_o never high.
- WIDTH=16, LANES=4, LSB_FIRST=1, beats 0x4,0xE,0x7,0xB with random val gaps -> 0xB7E4, len=16; the same beats with LSB_FIRST=0 -> 0x4E7B.
- WIDTH=16, LANES=1, LSB_FIRST=0, bits 1,0,1 with last on the third -> deser_data_o=0xA000, len=3; the next full word 0xFFFF is assembled correctly.
- ready=0, complete 0x1234 then 0x5678 -> output holds 0x1234, ovf_o pulses once; ready=1 for 1 cycle -> valid drops; with the macro, drop_cnt_o=1 and word_cnt_o=1.
- Assert arstn_i after 9 of 16 bits, release, send 0xCAFE -> only 0xCAFE emitted, len=16; all outputs are 0 during reset.
- FULL with ready=1 in the exact cycle a new word completes -> deser_data_val_o stays high, new word presented next cycle, ovf_o=0.
